// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-signal controller family: light codes,
// controller phase encoding and a constant-evaluable ceil(log2) helper.
package traffic_pkg;

  localparam logic [2:0] LT_GREEN  = 3'b001;
  localparam logic [2:0] LT_YELLOW = 3'b010;
  localparam logic [2:0] LT_RED    = 3'b100;

  typedef enum logic [1:0] {
    ALLRED = 2'b00,
    GREEN  = 2'b01,
    YELLOW = 2'b10
  } phase_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((32'd1 << r) < 32'(value)) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/tl_rr_select.sv
// Cyclic-priority search: returns the first set bit of req starting at index
// start and wrapping, so the bit just before start is examined last.
module tl_rr_select
  import traffic_pkg::*;
#(
  parameter int N = 4,
  parameter int W = clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic         found,
  output logic [W-1:0] idx
);

  logic [2*N-1:0] dbl_s;
  logic [N-1:0]   rot_s;
  logic [W-1:0]   off_s;
  logic [W:0]     sum_s;

  assign dbl_s = {req, req};
  assign rot_s = N'(dbl_s >> start);

  // Lowest set offset in the rotated vector; the descending loop lets it win.
  always_comb begin
    found = 1'b0;
    off_s = '0;
    for (int k = N - 1; k >= 0; k--) begin
      found = found | rot_s[k];
      off_s = rot_s[k] ? W'(k) : off_s;
    end
  end

  assign sum_s = {1'b0, start} + {1'b0, off_s};
  assign idx   = (sum_s >= (W+1)'(N)) ? W'(sum_s - (W+1)'(N)) : sum_s[W-1:0];

endmodule

// File: rtl/trafficlight_nway_ctrl.sv
// Demand-actuated N-approach signal controller: round-robin service with
// skip, gap-out, all-red clearance and emergency pre-emption, timed on tick.
module trafficlight_nway_ctrl
  import traffic_pkg::*;
#(
  parameter  int N_APP     = 4,
  parameter  int CNT_W     = 8,
  parameter  int GREEN_T   = 7,
  parameter  int MIN_GREEN = 3,
  parameter  int YELLOW_T  = 2,
  parameter  int ALLRED_T  = 1,
  localparam int DW        = clog2(N_APP)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic [N_APP-1:0]   demand,
  input  logic               emerg_req,
  input  logic [DW-1:0]      emerg_dir,
  output logic [3*N_APP-1:0] lights,
  output logic [DW-1:0]      active_dir,
  output logic [1:0]         phase
);

  phase_t           phase_r;
  logic [DW-1:0]    dir_r;
  logic [CNT_W-1:0] cnt_r;

  logic [DW-1:0]    start_s;
  logic [DW-1:0]    next_dir_s;
  logic [DW-1:0]    rr_idx_s;
  logic             rr_found_s;
  logic [N_APP-1:0] own_s;
  logic             emerg_vld_s;
  logic             emerg_here_s;
  logic             emerg_other_s;
  logic             gap_s;
  logic             green_done_s;

  assign start_s = (dir_r == DW'(N_APP - 1)) ? '0 : dir_r + DW'(1'b1);
  assign own_s   = N_APP'(1'b1) << dir_r;

  // Out-of-range directions (possible when N_APP is not a power of two) are ignored.
  assign emerg_vld_s   = emerg_req & ({1'b0, emerg_dir} < (DW+1)'(N_APP));
  assign emerg_here_s  = emerg_vld_s & (emerg_dir == dir_r);
  assign emerg_other_s = emerg_vld_s & (emerg_dir != dir_r);

  assign gap_s = (cnt_r >= CNT_W'(MIN_GREEN - 1)) & ~(|(demand & own_s))
               & (|(demand & ~own_s));
  assign green_done_s = (cnt_r == CNT_W'(GREEN_T - 1));

  tl_rr_select #(
    .N (N_APP),
    .W (DW)
  ) u_rr_select (
    .req   (demand),
    .start (start_s),
    .found (rr_found_s),
    .idx   (rr_idx_s)
  );

  // Next approach to serve: emergency first, then demand search, then fixed rotation.
  always_comb begin
    next_dir_s = start_s;
    if (emerg_vld_s) begin
      next_dir_s = emerg_dir;
    end else if (rr_found_s) begin
      next_dir_s = rr_idx_s;
    end else begin
      next_dir_s = start_s;
    end
  end

  // Phase sequencer and phase timer; everything advances only on tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_r <= ALLRED;
      cnt_r   <= '0;
      dir_r   <= DW'(N_APP - 1);
    end else if (tick) begin
      case (phase_r)
        ALLRED: begin
          if (cnt_r == CNT_W'(ALLRED_T - 1)) begin
            phase_r <= GREEN;
            cnt_r   <= '0;
            dir_r   <= next_dir_s;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1'b1);
          end
        end
        GREEN: begin
          if (emerg_here_s) begin
            cnt_r <= cnt_r;
          end else if (green_done_s || gap_s || emerg_other_s) begin
            phase_r <= YELLOW;
            cnt_r   <= '0;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1'b1);
          end
        end
        YELLOW: begin
          if (cnt_r == CNT_W'(YELLOW_T - 1)) begin
            phase_r <= ALLRED;
            cnt_r   <= '0;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1'b1);
          end
        end
        default: begin
          phase_r <= ALLRED;
          cnt_r   <= '0;
        end
      endcase
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Light decode: only the active approach ever leaves red.
  always_comb begin
    lights = {N_APP{LT_RED}};
    for (int i = 0; i < N_APP; i++) begin
      if (dir_r == DW'(i)) begin
        case (phase_r)
          GREEN:   lights[3*i +: 3] = LT_GREEN;
          YELLOW:  lights[3*i +: 3] = LT_YELLOW;
          default: lights[3*i +: 3] = LT_RED;
        endcase
      end else begin
        lights[3*i +: 3] = LT_RED;
      end
    end
  end

  assign active_dir = dir_r;
  assign phase      = phase_r;

endmodule

// File: tb/tb_trafficlight_nway_ctrl.sv
// Directed self-checking bench for trafficlight_nway_ctrl (N_APP=4 and N_APP=3).
module tb_trafficlight_nway_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tick = 1'b1;
  logic [3:0]  demand = 4'b0000;
  logic        emerg_req = 1'b0;
  logic [1:0]  emerg_dir = 2'd0;
  logic [11:0] lights;
  logic [1:0]  active_dir;
  logic [1:0]  phase;

  logic [2:0]  demand3 = 3'b000;
  logic        emerg_req3 = 1'b0;
  logic [1:0]  emerg_dir3 = 2'd0;
  logic [8:0]  lights3;
  logic [1:0]  active_dir3;
  logic [1:0]  phase3;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] P_AR = 2'b00;
  localparam logic [1:0] P_G  = 2'b01;
  localparam logic [1:0] P_Y  = 2'b10;

  trafficlight_nway_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .demand     (demand),
    .emerg_req  (emerg_req),
    .emerg_dir  (emerg_dir),
    .lights     (lights),
    .active_dir (active_dir),
    .phase      (phase)
  );

  trafficlight_nway_ctrl #(.N_APP(3)) dut3 (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .demand     (demand3),
    .emerg_req  (emerg_req3),
    .emerg_dir  (emerg_dir3),
    .lights     (lights3),
    .active_dir (active_dir3),
    .phase      (phase3)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] exp_l(input logic [1:0] ph, input int d);
    logic [11:0] v;
    v = 12'b100_100_100_100;
    if (ph == 2'b01) v[3*d +: 3] = 3'b001;
    else if (ph == 2'b10) v[3*d +: 3] = 3'b010;
    return v;
  endfunction

  function automatic logic [1:0] cyc_ph(input int c);
    return (c < 7) ? 2'b01 : (c < 9) ? 2'b10 : 2'b00;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick = 1'b1;
    emerg_req = 1'b0;
    emerg_req3 = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    int seq[5] = '{0, 1, 2, 3, 0};
    logic [1:0] ph;
    demand = 4'b1111;
    rst = 1'b0;
    step();
    checks++;
    if (lights !== 12'h924 || phase !== 2'b00 || active_dir !== 2'd3) begin
      errors++;
      $display("FAIL reset_hold: lights=%b phase=%b dir=%0d, expected 100100100100/00/3", lights, phase, active_dir);
    end
    rst = 1'b1;
    checks++;
    if (lights !== 12'h924 || phase !== 2'b00 || active_dir !== 2'd3) begin
      errors++;
      $display("FAIL reset_release: lights=%b phase=%b dir=%0d, expected 100100100100/00/3", lights, phase, active_dir);
    end
    step();
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < ((k == 4) ? 1 : 10); c++) begin
        ph = cyc_ph(c);
        checks++;
        if (lights !== exp_l(ph, seq[k]) || phase !== ph || active_dir !== 2'(seq[k])) begin
          errors++;
          $display("FAIL rr k=%0d c=%0d: lights=%b phase=%b dir=%0d, expected lights=%b phase=%b dir=%0d",
                   k, c, lights, phase, active_dir, exp_l(ph, seq[k]), ph, seq[k]);
        end
        step();
      end
    end
  endtask

  task automatic test_skip();
    int seq[4] = '{0, 3, 0, 3};
    logic [1:0] ph;
    demand = 4'b1001;
    do_reset();
    step();
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 10; c++) begin
        ph = cyc_ph(c);
        checks++;
        if (lights !== exp_l(ph, seq[k]) || phase !== ph || active_dir !== 2'(seq[k])) begin
          errors++;
          $display("FAIL skip k=%0d c=%0d: lights=%b phase=%b dir=%0d, expected lights=%b phase=%b dir=%0d",
                   k, c, lights, phase, active_dir, exp_l(ph, seq[k]), ph, seq[k]);
        end
        step();
      end
    end
  endtask

  task automatic test_gapout();
    logic [1:0] eph[7] = '{P_G, P_G, P_G, P_Y, P_Y, P_AR, P_G};
    int         edir[7] = '{0, 0, 0, 0, 0, 0, 1};
    demand = 4'b0011;
    do_reset();
    step();
    for (int i = 0; i < 7; i++) begin
      if (i == 0) demand = 4'b0010;
      checks++;
      if (lights !== exp_l(eph[i], edir[i]) || phase !== eph[i] || active_dir !== 2'(edir[i])) begin
        errors++;
        $display("FAIL gapout i=%0d: lights=%b phase=%b dir=%0d, expected lights=%b phase=%b dir=%0d",
                 i, lights, phase, active_dir, exp_l(eph[i], edir[i]), eph[i], edir[i]);
      end
      step();
    end
  endtask

  task automatic test_emergency();
    logic [1:0] ph;
    int d;
    demand = 4'b1111;
    do_reset();
    step();
    step();
    checks++;
    if (lights !== exp_l(P_G, 0) || phase !== P_G || active_dir !== 2'd0) begin
      errors++;
      $display("FAIL emerg_pre: lights=%b phase=%b dir=%0d, expected green on 0", lights, phase, active_dir);
    end
    emerg_dir = 2'd2;
    emerg_req = 1'b1;
    step();
    for (int i = 0; i < 34; i++) begin
      if (i == 23) emerg_req = 1'b0;
      if (i < 2)       begin ph = P_Y;  d = 0; end
      else if (i == 2) begin ph = P_AR; d = 0; end
      else if (i < 30) begin ph = P_G;  d = 2; end
      else if (i < 32) begin ph = P_Y;  d = 2; end
      else if (i == 32) begin ph = P_AR; d = 2; end
      else             begin ph = P_G;  d = 3; end
      checks++;
      if (lights !== exp_l(ph, d) || phase !== ph || active_dir !== 2'(d)) begin
        errors++;
        $display("FAIL emerg i=%0d: lights=%b phase=%b dir=%0d, expected lights=%b phase=%b dir=%0d",
                 i, lights, phase, active_dir, exp_l(ph, d), ph, d);
      end
      step();
    end
  endtask

  task automatic test_slow_tick();
    logic [1:0] ph;
    int d, p;
    demand = 4'b0000;
    do_reset();
    for (int c = 0; c < 75; c++) begin
      if (c < 4) begin
        ph = P_AR;
        d = 3;
      end else begin
        p = (c - 4) % 40;
        d = ((c - 4) / 40) % 4;
        ph = (p < 28) ? P_G : (p < 36) ? P_Y : P_AR;
      end
      checks++;
      if (lights !== exp_l(ph, d) || phase !== ph || active_dir !== 2'(d)) begin
        errors++;
        $display("FAIL slow_tick c=%0d: lights=%b phase=%b dir=%0d, expected lights=%b phase=%b dir=%0d",
                 c, lights, phase, active_dir, exp_l(ph, d), ph, d);
      end
      if (c < 74) begin
        tick = ((c % 4) == 3);
        step();
      end
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (lights !== 12'h924 || phase !== 2'b00 || active_dir !== 2'd3) begin
      errors++;
      $display("FAIL async_reset: lights=%b phase=%b dir=%0d, expected 100100100100/00/3", lights, phase, active_dir);
    end
  endtask

  task automatic test_invalid_emerg();
    int seq[4] = '{0, 1, 2, 0};
    logic [1:0] ph;
    logic [11:0] e;
    demand3 = 3'b111;
    do_reset();
    emerg_dir3 = 2'd3;
    emerg_req3 = 1'b1;
    checks++;
    if (lights3 !== 9'b100_100_100 || phase3 !== 2'b00 || active_dir3 !== 2'd2) begin
      errors++;
      $display("FAIL n3_reset: lights=%b phase=%b dir=%0d, expected 100100100/00/2", lights3, phase3, active_dir3);
    end
    step();
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < ((k == 3) ? 1 : 10); c++) begin
        ph = cyc_ph(c);
        e = exp_l(ph, seq[k]);
        checks++;
        if (lights3 !== e[8:0] || phase3 !== ph || active_dir3 !== 2'(seq[k])) begin
          errors++;
          $display("FAIL n3_invalid k=%0d c=%0d: lights=%b phase=%b dir=%0d, expected lights=%b phase=%b dir=%0d",
                   k, c, lights3, phase3, active_dir3, e[8:0], ph, seq[k]);
        end
        step();
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_skip();
    test_gapout();
    test_emergency();
    test_slow_tick();
    test_invalid_emerg();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/trafficlight_nway_ctrl.md
# trafficlight_nway_ctrl

Parametrised, demand-actuated traffic-signal controller for N approaches, the next generation of the team's fixed four-way sequencer. Serves one approach at a time in round-robin order and skips approaches with no vehicle demand. Ends a green early (gap-out) once minimum green has elapsed. Inserts an all-red clearance interval between phases and supports an emergency-vehicle pre-emption request. All durations count a `tick` time-base enable, so one design serves both simulation (tick tied high) and real-time boards.

## Interface
- `N_APP`, 4, number of approaches; legal range 2..8.
- `CNT_W`, 8, phase-timer width; must represent every duration parameter.
- `GREEN_T`, 7, maximum green duration in ticks; ≥1.
- `MIN_GREEN`, 3, minimum green before gap-out in ticks; 1 ≤ MIN_GREEN ≤ GREEN_T.
- `YELLOW_T`, 2, yellow duration in ticks; ≥1.
- `ALLRED_T`, 1, all-red clearance duration in ticks; ≥1.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `tick`  in  1  time-base enable; timers and state advance only on edges where tick=1.
- `demand`  in  N_APP  per-approach vehicle presence, level-sensitive.
- `emerg_req`  in  1  emergency pre-emption request, level-sensitive.
- `emerg_dir`  in  clog2(N_APP)  approach requested for pre-emption; values ≥ N_APP ignore the request.
- `lights`  out  3*N_APP  per approach {red,yellow,green} one-hot (001 green, 010 yellow, 100 red); approach i occupies bits [3i+2:3i].
- `active_dir`  out  clog2(N_APP)  approach currently or last served.
- `phase`  out  2  00 ALLRED, 01 GREEN, 10 YELLOW.

## Operation
- Registered state: `phase`, `active_dir`, timer `cnt`.
- Reset (rst=0, asynchronous): phase=ALLRED, cnt=0, active_dir=N_APP-1, so the first search starts at approach 0. All lights=100.
- `lights` is a combinational decode of phase/active_dir. Non-active approaches are always 100. The active approach shows 001 in GREEN, 010 in YELLOW, and 100 in ALLRED.
- Each state lasts exactly T ticks. On a tick, if cnt==T-1, take the transition and clear cnt; otherwise increment cnt.
- **ALLRED → GREEN** after ALLRED_T ticks. The new active_dir is chosen as follows:
  - If an emergency is valid, choose emerg_dir.
  - Otherwise, choose the first approach with demand=1, searching cyclically from active_dir+1 with active_dir itself checked last.
  - If no approach has demand, choose active_dir+1 mod N_APP (fixed-time fallback).
- **GREEN → YELLOW**, evaluated only on tick edges:
  - (a) after GREEN_T ticks; or
  - (b) gap-out: cnt ≥ MIN_GREEN-1, demand[active_dir]=0, and some other approach has demand=1; or
  - (c) a valid emergency for a different approach. This transition happens on the next tick, even if MIN_GREEN has not elapsed, and clears cnt.
- **GREEN hold**: while a valid emergency targets active_dir, cnt is frozen and green is held indefinitely. On release, counting resumes from the frozen value.
- **YELLOW → ALLRED** after YELLOW_T ticks. YELLOW and ALLRED are never cut short by an emergency; the request is honoured at the next ALLRED exit.
- If the emergency targets the approach currently in YELLOW, the cycle completes and that approach is re-served next.
- Simultaneous gap-out and GREEN_T expiry produce a single transition to YELLOW.
- A change to `demand` mid-state has effect only at the next evaluation point.

## Timing
- With tick=1 continuously, using the defaults: green 7 cycles, yellow 2, all-red 1, for a 10-cycle period per approach.
- State and output change one clk edge after the deciding tick edge. There is no output pipeline latency beyond the state register.
- Reset assertion forces all-red immediately (asynchronous). Release is taken on the next clk edge; the first green follows ALLRED_T ticks after release.
- Inputs are synchronous to clk. Synchronising `demand` and `emerg_req` is the integrator's responsibility.

## Structure
- Shared package `traffic_pkg`:
  - light encodings LT_GREEN=3'b001, LT_YELLOW=3'b010, LT_RED=3'b100;
  - phase enum ALLRED/GREEN/YELLOW;
  - clog2 helper.
- Sub-module `tl_rr_select`: combinational cyclic-priority search over `demand`. Takes the start index and outputs the found flag and index. It is reused by the pedestrian controller.
- The top level holds the FSM, timer, emergency qualification, and light decode.

## Test plan
Defaults throughout: N_APP=4, tick=1.
1. Reset with demand=1111: lights all 100 during reset. After release, 1 all-red cycle, then approach 0 green for 7 cycles, yellow 2, all-red 1, then approach 1 green; sequence 0,1,2,3,0.
2. Skip: demand=1001 → greens alternate 0,3,0,3. Approaches 1 and 2 stay 100 throughout.
3. Gap-out: demand=0011, with demand[0] dropped at green cycle 1 → approach 0 turns yellow after its 3rd green cycle, then approach 1 green.
4. Emergency: at approach-0 green cycle 2, emerg_req=1 with emerg_dir=2 → yellow next cycle, 2 yellow, 1 all-red, then approach 2 held green for 20 cycles. Release → 7 more green cycles, then approach 3 if it has demand.
5. tick every 4th cycle with demand=0000 → fixed round robin with green lasting 28 cycles. An asynchronous reset mid-yellow forces all lights to 100 within the same cycle.
6. Invalid request: emerg_dir=3 with N_APP=3 (parameter override) → request ignored and normal sequencing continues.
